// File: rtl/frame_pkg.sv
// Shared frame geometry, bus widths and reader FSM encoding for the frame buffer,
// reader and window blocks.
package frame_pkg;

  localparam int H_ACT     = 480;
  localparam int V_ACT     = 272;
  localparam int FRAME_PIX = H_ACT * V_ACT;
  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 24;
  localparam int RD_LAT    = 1;
  localparam int SKID_D    = 4;
  localparam int XY_W      = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Raster coordinate step: returns zero after the last position of the line/frame.
  function automatic logic [XY_W-1:0] wrap_inc(input logic [XY_W-1:0] v,
                                               input logic [XY_W-1:0] last);
    logic [XY_W-1:0] r;
    if (v == last) begin
      r = {XY_W{1'b0}};
    end else begin
      r = v + {{(XY_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_rd_ctrl_if.sv
// Buffer read port plus tagged pixel stream between the frame reader and its neighbours.
interface frame_rd_ctrl_if #(
  parameter int ADDR_W = frame_pkg::ADDR_W,
  parameter int DATA_W = frame_pkg::DATA_W
) ();

  logic                       rd_en;
  logic [ADDR_W-1:0]          rd_addr;
  logic [DATA_W-1:0]          rd_data;
  logic                       pix_valid;
  logic                       pix_ready;
  logic [DATA_W-1:0]          pix_data;
  logic [frame_pkg::XY_W-1:0] pix_x;
  logic [frame_pkg::XY_W-1:0] pix_y;
  logic                       sof;
  logic                       eol;
  logic                       eof;

  modport master (
    output rd_en, rd_addr, pix_valid, pix_data, pix_x, pix_y, sof, eol, eof,
    input  rd_data, pix_ready
  );

  modport slave (
    input  rd_en, rd_addr, pix_valid, pix_data, pix_x, pix_y, sof, eol, eof,
    output rd_data, pix_ready
  );

endinterface

// File: rtl/sync_skid_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible on o_data whenever o_valid is high.
module sync_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = i_pop & (count_r != {CNT_W{1'b0}});
  assign do_push_s = i_push & ((count_r != CNT_W'(DEPTH)) | do_pop_s);

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= i_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  assign o_data  = mem_r[rd_ptr_r];
  assign o_valid = (count_r != {CNT_W{1'b0}});
  assign o_count = count_r;

endmodule

// File: rtl/frame_rd_ctrl.sv
// Frame buffer reader: walks the readable bank in raster order and streams x/y/frame-tagged
// pixels through a credit-controlled skid FIFO that absorbs the BRAM read latency.
module frame_rd_ctrl #(
  parameter int H_ACT  = frame_pkg::H_ACT,
  parameter int V_ACT  = frame_pkg::V_ACT,
  parameter int ADDR_W = frame_pkg::ADDR_W,
  parameter int DATA_W = frame_pkg::DATA_W,
  parameter int RD_LAT = frame_pkg::RD_LAT,
  parameter int SKID_D = frame_pkg::SKID_D
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  frame_rd_ctrl_if.master bus,
  output logic            o_busy,
  output logic            o_overrun
);

  localparam int FRAME_PIX = H_ACT * V_ACT;
  localparam int XY_W      = frame_pkg::XY_W;
  localparam int CNT_W     = $clog2(SKID_D) + 1;
  localparam int CRD_W     = CNT_W + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam logic [XY_W-1:0]   X_LAST    = XY_W'(H_ACT - 1);
  localparam logic [XY_W-1:0]   Y_LAST    = XY_W'(V_ACT - 1);

  frame_pkg::rd_state_e state_r;
  frame_pkg::rd_state_e state_next_s;
  logic                 rd_en_r;
  logic                 rd_en_next_s;
  logic [ADDR_W-1:0]    rd_addr_r;
  logic [RD_LAT-1:0]    pipe_r;
  logic [XY_W-1:0]      x_r;
  logic [XY_W-1:0]      y_r;
  logic                 busy_r;
  logic                 overrun_r;
  logic                 push_s;
  logic                 pop_s;
  logic                 start_ok_s;
  logic                 last_addr_s;
  logic                 credit_ok_s;
  logic                 drain_done_s;
  logic [CRD_W-1:0]     inflight_s;
  logic [CRD_W-1:0]     credit_used_s;
  logic                 fifo_valid_s;
  logic [DATA_W-1:0]    fifo_data_s;
  logic [CNT_W-1:0]     fifo_count_s;

  sync_skid_fifo #(
    .DEPTH (SKID_D),
    .WIDTH (DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_s),
    .i_data  (bus.rd_data),
    .i_pop   (pop_s),
    .o_data  (fifo_data_s),
    .o_valid (fifo_valid_s),
    .o_count (fifo_count_s)
  );

  assign push_s      = pipe_r[RD_LAT-1];
  assign pop_s       = fifo_valid_s & bus.pix_ready;
  assign start_ok_s  = i_start & (state_r == frame_pkg::ST_IDLE);
  assign last_addr_s = (rd_addr_r == LAST_ADDR);

  // Credits: the next read may issue only if every slot it could land in is already free.
  always_comb begin
    inflight_s = {CRD_W{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + CRD_W'(pipe_r[i]);
    end
    credit_used_s = CRD_W'(fifo_count_s) + inflight_s + CRD_W'(rd_en_r) - CRD_W'(pop_s);
    credit_ok_s   = (credit_used_s < CRD_W'(SKID_D));
    drain_done_s  = (inflight_s == {CRD_W{1'b0}}) &&
                    ((fifo_count_s == {CNT_W{1'b0}}) ||
                     ((fifo_count_s == CNT_W'(1'b1)) && pop_s));
  end

  // FSM next state and next-cycle read issue.
  always_comb begin
    state_next_s = state_r;
    rd_en_next_s = 1'b0;
    case (state_r)
      frame_pkg::ST_IDLE: begin
        if (i_start) begin
          state_next_s = frame_pkg::ST_READ;
          rd_en_next_s = 1'b1;
        end else begin
          state_next_s = frame_pkg::ST_IDLE;
        end
      end
      frame_pkg::ST_READ: begin
        if (rd_en_r && last_addr_s) begin
          state_next_s = frame_pkg::ST_DRAIN;
        end else begin
          rd_en_next_s = credit_ok_s;
        end
      end
      frame_pkg::ST_DRAIN: begin
        if (drain_done_s) begin
          state_next_s = frame_pkg::ST_IDLE;
        end else begin
          state_next_s = frame_pkg::ST_DRAIN;
        end
      end
      default: begin
        state_next_s = frame_pkg::ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= frame_pkg::ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Read port, latency pipe, raster position and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_en_r   <= 1'b0;
      rd_addr_r <= {ADDR_W{1'b0}};
      pipe_r    <= {RD_LAT{1'b0}};
      x_r       <= {XY_W{1'b0}};
      y_r       <= {XY_W{1'b0}};
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      rd_en_r   <= rd_en_next_s;
      pipe_r[0] <= rd_en_r;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
      // The address already points at the next read while a stall is in progress.
      if (start_ok_s) begin
        rd_addr_r <= {ADDR_W{1'b0}};
      end else if (rd_en_r && !last_addr_s) begin
        rd_addr_r <= rd_addr_r + ADDR_W'(1'b1);
      end
      if (start_ok_s) begin
        x_r <= {XY_W{1'b0}};
        y_r <= {XY_W{1'b0}};
      end else if (pop_s) begin
        x_r <= frame_pkg::wrap_inc(x_r, X_LAST);
        if (x_r == X_LAST) begin
          y_r <= frame_pkg::wrap_inc(y_r, Y_LAST);
        end
      end
      busy_r    <= (state_next_s != frame_pkg::ST_IDLE);
      overrun_r <= i_start & (state_r != frame_pkg::ST_IDLE);
    end
  end

  assign bus.rd_en     = rd_en_r;
  assign bus.rd_addr   = rd_addr_r;
  assign bus.pix_valid = fifo_valid_s;
  assign bus.pix_data  = fifo_data_s;
  assign bus.pix_x     = x_r;
  assign bus.pix_y     = y_r;
  assign bus.sof       = fifo_valid_s & (x_r == {XY_W{1'b0}}) & (y_r == {XY_W{1'b0}});
  assign bus.eol       = fifo_valid_s & (x_r == X_LAST);
  assign bus.eof       = fifo_valid_s & (x_r == X_LAST) & (y_r == Y_LAST);
  assign o_busy        = busy_r;
  assign o_overrun     = overrun_r;

endmodule

// File: tb/tb_frame_rd_ctrl.sv
// Directed bench for frame_rd_ctrl: small frames at both read latencies plus wide/tall frames
// exercising the x=479 and y=271 coordinate limits.
module tb_frame_rd_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_cd = 1'b0;
  logic busy_a, busy_b, busy_c, busy_d;
  logic ovr_a, ovr_b, ovr_c, ovr_d;
  logic [23:0] qa, qb1, qb2, qc, qd;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  frame_rd_ctrl_if #(.ADDR_W(17), .DATA_W(24)) ifa ();
  frame_rd_ctrl_if #(.ADDR_W(17), .DATA_W(24)) ifb ();
  frame_rd_ctrl_if #(.ADDR_W(17), .DATA_W(24)) ifc ();
  frame_rd_ctrl_if #(.ADDR_W(17), .DATA_W(24)) ifd ();

  // Buffer models: data = address, returned RD_LAT clocks after the read enable.
  always @(posedge clk) begin
    if (ifa.rd_en) qa <= 24'(ifa.rd_addr);
    if (ifb.rd_en) qb1 <= 24'(ifb.rd_addr);
    qb2 <= qb1;
    if (ifc.rd_en) qc <= 24'(ifc.rd_addr);
    if (ifd.rd_en) qd <= 24'(ifd.rd_addr);
  end
  assign ifa.rd_data = qa;
  assign ifb.rd_data = qb2;
  assign ifc.rd_data = qc;
  assign ifd.rd_data = qd;
  assign ifb.pix_ready = 1'b1;
  assign ifc.pix_ready = 1'b1;
  assign ifd.pix_ready = 1'b1;

  frame_rd_ctrl #(.H_ACT(8), .V_ACT(4), .ADDR_W(17), .DATA_W(24), .RD_LAT(1), .SKID_D(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .bus(ifa.master), .o_busy(busy_a), .o_overrun(ovr_a));
  frame_rd_ctrl #(.H_ACT(8), .V_ACT(4), .ADDR_W(17), .DATA_W(24), .RD_LAT(2), .SKID_D(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .bus(ifb.master), .o_busy(busy_b), .o_overrun(ovr_b));
  frame_rd_ctrl #(.H_ACT(480), .V_ACT(4), .ADDR_W(17), .DATA_W(24), .RD_LAT(1), .SKID_D(4)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_cd), .bus(ifc.master), .o_busy(busy_c), .o_overrun(ovr_c));
  frame_rd_ctrl #(.H_ACT(4), .V_ACT(272), .ADDR_W(17), .DATA_W(24), .RD_LAT(1), .SKID_D(4)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_cd), .bus(ifd.master), .o_busy(busy_d), .o_overrun(ovr_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifa.pix_ready = 1'b0;
    tick();
    tick();
    n_total++;
    if ({ifa.rd_en, ifa.pix_valid, ifa.sof, ifa.eol, ifa.eof, busy_a, ovr_a} !== 7'b0)
      $display("FAIL reset_flags: got %b want 0000000",
               {ifa.rd_en, ifa.pix_valid, ifa.sof, ifa.eol, ifa.eof, busy_a, ovr_a});
    else n_pass++;
    n_total++;
    if ({ifa.rd_addr, ifa.pix_data, ifa.pix_x, ifa.pix_y} !== 59'd0)
      $display("FAIL reset_values: addr %0d data %0h x %0d y %0d want all 0",
               ifa.rd_addr, ifa.pix_data, ifa.pix_x, ifa.pix_y);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    logic exp_en, exp_v;
    logic [2:0] exp_f;
    ifa.pix_ready = 1'b1;
    start_a = 1'b1;
    for (int k = 0; k <= 38; k++) begin
      if (k > 0) begin tick(); start_a = 1'b0; end
      exp_en = (k >= 1 && k <= 32);
      exp_v  = (k >= 3 && k <= 34);
      n_total++;
      if (ifa.rd_en !== exp_en) $display("FAIL nom_rd_en cyc %0d: got %b want %b", k, ifa.rd_en, exp_en);
      else n_pass++;
      if (exp_en) begin
        n_total++;
        if (ifa.rd_addr !== 17'(k - 1)) $display("FAIL nom_addr cyc %0d: got %0d want %0d", k, ifa.rd_addr, k - 1);
        else n_pass++;
      end
      n_total++;
      if (ifa.pix_valid !== exp_v) $display("FAIL nom_valid cyc %0d: got %b want %b", k, ifa.pix_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        exp_f = {(k == 3), ((k - 3) % 8 == 7), (k == 34)};
        n_total++;
        if (ifa.pix_data !== 24'(k - 3)) $display("FAIL nom_data cyc %0d: got %0d want %0d", k, ifa.pix_data, k - 3);
        else n_pass++;
        n_total++;
        if ({ifa.sof, ifa.eol, ifa.eof} !== exp_f)
          $display("FAIL nom_markers cyc %0d: got %b want %b", k, {ifa.sof, ifa.eol, ifa.eof}, exp_f);
        else n_pass++;
      end
      n_total++;
      if (busy_a !== (k >= 1 && k <= 34)) $display("FAIL nom_busy cyc %0d: got %b", k, busy_a);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    logic prev_stall = 1'b0;
    logic [23:0] prev_data = 24'd0;
    start_a = 1'b1;
    for (int k = 0; k < 200 && idx < 32; k++) begin
      if (k > 0) begin tick(); start_a = 1'b0; end
      ifa.pix_ready = (k % 3 == 0);
      n_total++;
      if (dut_a.u_fifo.o_count > 3'd4) $display("FAIL bp_count cyc %0d: got %0d want <=4", k, dut_a.u_fifo.o_count);
      else n_pass++;
      if (prev_stall) begin
        n_total++;
        if (!(ifa.pix_valid === 1'b1 && ifa.pix_data === prev_data))
          $display("FAIL bp_hold cyc %0d: got v=%b d=%0d want v=1 d=%0d", k, ifa.pix_valid, ifa.pix_data, prev_data);
        else n_pass++;
      end
      if (ifa.pix_valid && ifa.pix_ready) begin
        n_total++;
        if (ifa.pix_data !== 24'(idx) || ifa.pix_x !== 9'(idx % 8) || ifa.pix_y !== 9'(idx / 8))
          $display("FAIL bp_seq: got d=%0d x=%0d y=%0d want d=%0d x=%0d y=%0d",
                   ifa.pix_data, ifa.pix_x, ifa.pix_y, idx, idx % 8, idx / 8);
        else n_pass++;
        idx++;
      end
      prev_stall = ifa.pix_valid && !ifa.pix_ready;
      prev_data  = ifa.pix_data;
    end
    n_total++;
    if (idx != 32) $display("FAIL bp_total: got %0d want 32", idx);
    else n_pass++;
    ifa.pix_ready = 1'b1;
    for (int k = 0; k < 10 && busy_a; k++) tick();
    tick();
    n_total++;
    if (busy_a !== 1'b0 || ifa.pix_valid !== 1'b0) $display("FAIL bp_end: got busy=%b valid=%b want 0 0", busy_a, ifa.pix_valid);
    else n_pass++;
  endtask

  task automatic test_lat2();
    logic exp_v;
    start_b = 1'b1;
    for (int k = 0; k <= 37; k++) begin
      if (k > 0) begin tick(); start_b = 1'b0; end
      exp_v = (k >= 4 && k <= 35);
      n_total++;
      if (ifb.pix_valid !== exp_v) $display("FAIL lat2_valid cyc %0d: got %b want %b", k, ifb.pix_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        n_total++;
        if (ifb.pix_data !== 24'(k - 4)) $display("FAIL lat2_data cyc %0d: got %0d want %0d", k, ifb.pix_data, k - 4);
        else n_pass++;
      end
      n_total++;
      if (busy_b !== (k >= 1 && k <= 35)) $display("FAIL lat2_busy cyc %0d: got %b", k, busy_b);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    logic exp_v;
    ifa.pix_ready = 1'b1;
    for (int k = 0; k <= 45; k++) begin
      if (k > 0) tick();
      start_a = (k == 0 || k == 10 || k == 34 || k == 36);
      exp_v = (k >= 3 && k <= 34) || (k >= 39);
      n_total++;
      if (ovr_a !== (k == 11 || k == 35)) $display("FAIL ovr_pulse cyc %0d: got %b", k, ovr_a);
      else n_pass++;
      n_total++;
      if (ifa.pix_valid !== exp_v) $display("FAIL ovr_valid cyc %0d: got %b want %b", k, ifa.pix_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        n_total++;
        if (ifa.pix_data !== 24'((k <= 34) ? k - 3 : k - 39))
          $display("FAIL ovr_data cyc %0d: got %0d want %0d", k, ifa.pix_data, (k <= 34) ? k - 3 : k - 39);
        else n_pass++;
      end
      if (k >= 35 && k <= 37) begin
        n_total++;
        if (ifa.rd_en !== (k == 37) || (k == 37 && ifa.rd_addr !== 17'd0))
          $display("FAIL ovr_restart cyc %0d: got en=%b addr=%0d", k, ifa.rd_en, ifa.rd_addr);
        else n_pass++;
      end
      if (k == 39) begin
        n_total++;
        if (ifa.sof !== 1'b1) $display("FAIL ovr_sof: got %b want 1", ifa.sof);
        else n_pass++;
      end
    end
    start_a = 1'b0;
    for (int k = 0; k < 60 && busy_a; k++) tick();
    n_total++;
    if (busy_a !== 1'b0) $display("FAIL ovr_timeout: busy still %b", busy_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_mid_reset();
    ifa.pix_ready = 1'b1;
    start_a = 1'b1;
    for (int k = 1; k <= 15; k++) begin tick(); start_a = 1'b0; end
    n_total++;
    if (ifa.pix_valid !== 1'b1 || ifa.pix_data !== 24'd12) $display("FAIL rst_pre: got v=%b d=%0d want v=1 d=12", ifa.pix_valid, ifa.pix_data);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({ifa.rd_en, ifa.pix_valid, ifa.sof, ifa.eol, ifa.eof, busy_a, ovr_a} !== 7'b0)
      $display("FAIL rst_async_flags: got %b want 0", {ifa.rd_en, ifa.pix_valid, ifa.sof, ifa.eol, ifa.eof, busy_a, ovr_a});
    else n_pass++;
    n_total++;
    if ({ifa.rd_addr, ifa.pix_data, ifa.pix_x, ifa.pix_y} !== 59'd0)
      $display("FAIL rst_async_values: addr %0d data %0d x %0d y %0d want 0", ifa.rd_addr, ifa.pix_data, ifa.pix_x, ifa.pix_y);
    else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_total++;
      if (ifa.pix_valid !== 1'b0 || ifa.rd_en !== 1'b0 || busy_a !== 1'b0)
        $display("FAIL rst_quiet: got v=%b en=%b busy=%b want 0", ifa.pix_valid, ifa.rd_en, busy_a);
      else n_pass++;
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_total++;
    if (ifa.rd_en !== 1'b1 || ifa.rd_addr !== 17'd0) $display("FAIL rst_restart: got en=%b addr=%0d want 1 0", ifa.rd_en, ifa.rd_addr);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (ifa.pix_valid !== 1'b1 || ifa.pix_data !== 24'd0 || ifa.sof !== 1'b1)
      $display("FAIL rst_first: got v=%b d=%0d sof=%b want 1 0 1", ifa.pix_valid, ifa.pix_data, ifa.sof);
    else n_pass++;
    for (int k = 0; k < 60 && busy_a; k++) tick();
    n_total++;
    if (busy_a !== 1'b0) $display("FAIL rst_timeout: busy still %b", busy_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_full_frame();
    int n_c = 0, n_d = 0, err_c = 0, err_d = 0, eol_c = 0, eol_d = 0, max_c = 0, max_d = 0;
    logic [8:0] lx_c = 9'd0, ly_c = 9'd0, lx_d = 9'd0, ly_d = 9'd0;
    logic le_c = 1'b0, le_d = 1'b0;
    start_cd = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      if (k > 0) begin tick(); start_cd = 1'b0; end
      if (k > 1 && !busy_c && !busy_d) break;
      if (ifc.rd_en && int'(ifc.rd_addr) > max_c) max_c = int'(ifc.rd_addr);
      if (ifd.rd_en && int'(ifd.rd_addr) > max_d) max_d = int'(ifd.rd_addr);
      if (ifc.pix_valid) begin
        if (ifc.pix_data !== 24'(n_c)) err_c++;
        if (ifc.eol) eol_c++;
        lx_c = ifc.pix_x; ly_c = ifc.pix_y; le_c = ifc.eof; n_c++;
      end
      if (ifd.pix_valid) begin
        if (ifd.pix_data !== 24'(n_d)) err_d++;
        if (ifd.eol) eol_d++;
        lx_d = ifd.pix_x; ly_d = ifd.pix_y; le_d = ifd.eof; n_d++;
      end
    end
    n_total++;
    if (busy_c || busy_d) $display("FAIL wide_timeout: busy_c=%b busy_d=%b want 0", busy_c, busy_d);
    else n_pass++;
    n_total++;
    if (n_c != 1920 || err_c != 0 || eol_c != 4) $display("FAIL wide_stream: got n=%0d err=%0d eol=%0d want 1920 0 4", n_c, err_c, eol_c);
    else n_pass++;
    n_total++;
    if (lx_c !== 9'd479 || ly_c !== 9'd3 || le_c !== 1'b1 || max_c != 1919)
      $display("FAIL wide_last: got x=%0d y=%0d eof=%b maxaddr=%0d want 479 3 1 1919", lx_c, ly_c, le_c, max_c);
    else n_pass++;
    n_total++;
    if (n_d != 1088 || err_d != 0 || eol_d != 272) $display("FAIL tall_stream: got n=%0d err=%0d eol=%0d want 1088 0 272", n_d, err_d, eol_d);
    else n_pass++;
    n_total++;
    if (lx_d !== 9'd3 || ly_d !== 9'd271 || le_d !== 1'b1 || max_d != 1087)
      $display("FAIL tall_last: got x=%0d y=%0d eof=%b maxaddr=%0d want 3 271 1 1087", lx_d, ly_d, le_d, max_d);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_lat2();
    test_overrun();
    test_mid_reset();
    test_full_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
